booth_r4_multiplier: RTL and testbench

- Parametrised sequential radix-4 Booth multiplier: next generation of the team's fixed 64x64 radix-2 start/clear/done multiplier.
- Adds a WIDTH parameter, a per-operation signed/unsigned mode, two product bits per cycle and a busy flag.
- Sits beside the datapath as a multi-cycle coprocessor, driven by a controller through the op_start/op_clear/op_done handshake.

---
 rtl/booth_r4_multiplier.sv | 105 ++++++++++
 tb/tb_booth_r4_multiplier.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier with a start/clear/done handshake.
// Two product bits per cycle; signed or unsigned operands are selected for each operation.
module booth_r4_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int N    = WIDTH + 2;
  localparam int ITER = N / 2;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_reg, state_next;
  logic [N:0]          a_reg;       // {A, A[-1]}, shifted right two bits per step
  logic [2*N-1:0]      b_reg;       // sign-extended B, pre-scaled by 4^i
  logic [2*N-1:0]      acc_reg, acc_next, pp;
  logic [CW-1:0]       count_reg;
  logic [2*WIDTH-1:0]  result_reg;
  logic [N-1:0]        a_ext, b_ext;
  logic                last_iter;

  // The mode is captured through the two extension bits, so it needs no register of its own.
  assign a_ext = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                             : {2'b00, multiplier};
  assign b_ext = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                             : {2'b00, multiplicand};

  assign last_iter = (count_reg == CW'(ITER - 1));

  always_comb begin
    pp = '0;
    case (a_reg[2:0])
      3'b001, 3'b010: pp = b_reg;
      3'b011:         pp = b_reg << 1;
      3'b100:         pp = -(b_reg << 1);
      3'b101, 3'b110: pp = -b_reg;
      default:        pp = '0;
    endcase
    acc_next = acc_reg + pp;
  end

  always_comb begin
    state_next = state_reg;
    if (op_clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (op_start)  state_next = BUSY;
        BUSY:    if (last_iter) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || op_clear) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (op_start) begin
            a_reg     <= {a_ext, 1'b0};
            b_reg     <= {{N{b_ext[N-1]}}, b_ext};
            acc_reg   <= '0;
            count_reg <= '0;
          end
        end
        BUSY: begin
          acc_reg   <= acc_next;
          a_reg     <= a_reg >> 2;
          b_reg     <= b_reg << 2;
          count_reg <= count_reg + CW'(1);
          if (last_iter) result_reg <= acc_next[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_reg == BUSY);
  assign op_done = (state_reg == DONE);
  assign result  = result_reg;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Scoreboard bench: WIDTH=64 and WIDTH=8 multipliers, expected products queued at start, checked at done.
module tb_booth_r4_multiplier;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start64, clear64, sm64;
  logic [63:0]   a64, b64;
  logic          busy64, done64;
  logic [127:0]  res64;

  logic          start8, clear8, sm8;
  logic [7:0]    a8, b8;
  logic          busy8, done8;
  logic [15:0]   res8;

  booth_r4_multiplier #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .op_start(start64), .op_clear(clear64),
    .signed_mode(sm64), .multiplier(a64), .multiplicand(b64),
    .busy(busy64), .op_done(done64), .result(res64)
  );

  booth_r4_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .op_start(start8), .op_clear(clear8),
    .signed_mode(sm8), .multiplier(a8), .multiplicand(b8),
    .busy(busy8), .op_done(done8), .result(res8)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] sb64[$];
  logic [15:0]  sb8[$];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [127:0] model64(input logic [63:0] a, input logic [63:0] b, input logic sm);
    logic [127:0] ea, eb;
    ea = sm ? {{64{a[63]}}, a} : {64'd0, a};
    eb = sm ? {{64{b[63]}}, b} : {64'd0, b};
    return ea * eb;
  endfunction

  // Drive one start, count busy cycles, then pop the scoreboard on op_done.
  task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic sm, input logic [127:0] exp);
    int cnt;
    @(negedge clk);
    start64 = 1'b1; a64 = a; b64 = b; sm64 = sm;
    sb64.push_back(exp);
    @(negedge clk);
    start64 = 1'b0; a64 = '1; b64 = '1; sm64 = ~sm;
    cnt = 0;
    while (busy64 && cnt < 200) begin
      if (done64) check_val({tag, "_busy_done_excl"}, 1, 0);
      cnt++;
      @(negedge clk);
    end
    check_val({tag, "_latency"}, 128'(cnt), 128'd33);
    check_val({tag, "_done"}, 128'(done64), 128'd1);
    if (sb64.size() > 0) check_val({tag, "_result"}, res64, sb64.pop_front());
  endtask

  task automatic clear64_op(input string tag);
    @(negedge clk);
    clear64 = 1'b1;
    @(negedge clk);
    clear64 = 1'b0;
    check_val({tag, "_clr_result"}, res64, 128'd0);
    check_val({tag, "_clr_done"}, 128'(done64), 128'd0);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sm, input logic [15:0] exp);
    int cnt;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    sb8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0; a8 = '0; b8 = '0;
    cnt = 0;
    while (busy8 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check_val({tag, "_latency"}, 128'(cnt), 128'd5);
    check_val({tag, "_done"}, 128'(done8), 128'd1);
    if (sb8.size() > 0) check_val({tag, "_result"}, 128'(res8), 128'(sb8.pop_front()));
    @(negedge clk);
    clear8 = 1'b1;
    @(negedge clk);
    clear8 = 1'b0;
    check_val({tag, "_clr_result"}, 128'(res8), 128'd0);
  endtask

  // Start an operation, abort it after ten busy cycles with clear or reset.
  task automatic abort64(input string tag, input logic use_reset);
    int cnt;
    int done_seen;
    @(negedge clk);
    start64 = 1'b1; a64 = 64'd1100; b64 = -64'sd10; sm64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    check_val({tag, "_busy_before_abort"}, 128'(busy64), 128'd1);
    if (use_reset) reset = 1'b1; else clear64 = 1'b1;
    @(negedge clk);
    reset = 1'b0; clear64 = 1'b0;
    check_val({tag, "_busy_after_abort"}, 128'(busy64), 128'd0);
    check_val({tag, "_result_after_abort"}, res64, 128'd0);
    done_seen = 0;
    cnt = 0;
    while (cnt < 40) begin
      if (done64 || busy64) done_seen = 1;
      cnt++;
      @(negedge clk);
    end
    check_val({tag, "_no_done"}, 128'(done_seen), 128'd0);
    run64({tag, "_7x7"}, 64'd7, 64'd7, 1'b1, 128'd49);
    clear64_op({tag, "_7x7"});
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic rs;
    int cnt;
    reset = 1'b1;
    start64 = 0; clear64 = 0; sm64 = 0; a64 = 0; b64 = 0;
    start8 = 0; clear8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("rst_busy64", 128'(busy64), 128'd0);
    check_val("rst_done64", 128'(done64), 128'd0);
    check_val("rst_result64", res64, 128'd0);
    check_val("rst_result8", 128'(res8), 128'd0);

    run64("s_1100xm10", 64'd1100, -64'sd10, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_D508);
    start64 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("hold_done", 128'(done64), 128'd1);
      check_val("hold_result", res64, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_D508);
    end
    start64 = 1'b0;
    clear64_op("s_1100xm10");

    run64("s_ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    clear64_op("s_ones_x2");
    run64("u_ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE);
    clear64_op("u_ones_x2");
    run64("s_minxmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
          128'h4000_0000_0000_0000_0000_0000_0000_0000);
    clear64_op("s_minxmin");
    run64("u_maxxmax", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    clear64_op("u_maxxmax");
    run64("u_7x7", 64'd7, 64'd7, 1'b0, 128'd49);
    clear64_op("u_7x7");
    run64("s_0xn", 64'd0, 64'h1234_5678_9ABC_DEF0, 1'b1, 128'd0);
    clear64_op("s_0xn");

    for (int k = 0; k < 4; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = k[0];
      run64($sformatf("rand%0d", k), ra, rb, rs, model64(ra, rb, rs));
      clear64_op($sformatf("rand%0d", k));
    end

    run8("w8_s_minxmin", 8'h80, 8'h80, 1'b1, 16'h4000);
    run8("w8_u_maxxmax", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run8("w8_s_m19x10", 8'hED, 8'd10, 1'b1, 16'hFF42);

    abort64("abort_clear", 1'b0);
    abort64("abort_reset", 1'b1);

    // Clear beats start in IDLE; the start is taken once clear drops.
    @(negedge clk);
    start64 = 1'b1; clear64 = 1'b1; a64 = 64'd7; b64 = 64'd7; sm64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("both_high_busy", 128'(busy64), 128'd0);
    end
    clear64 = 1'b0;
    sb64.push_back(128'd49);
    @(negedge clk);
    start64 = 1'b0;
    check_val("start_after_clear_busy", 128'(busy64), 128'd1);
    cnt = 0;
    while (busy64 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check_val("start_after_clear_latency", 128'(cnt), 128'd33);
    check_val("start_after_clear_result", res64, sb64.pop_front());
    clear64_op("start_after_clear");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
